// File: rtl/jpeg_pkg.sv
// Shared JPEG block constants: block size, coefficient type and the zigzag -> raster map.
package jpeg_pkg;

  localparam int BLK_SIZE = 64;
  localparam int COEF_W   = 12;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Entry k is the raster position (row*8+col) of the k-th coefficient in zigzag scan.
  localparam logic [5:0] ZZ2RASTER [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] zz2raster(input logic [5:0] zz_idx);
    return ZZ2RASTER[zz_idx];
  endfunction

endpackage

// File: rtl/izigzag_buffer_lut.sv
// Combinational zigzag index -> raster index map.
module izigzag_lut
  import jpeg_pkg::*;
(
  input  logic [5:0] zz_idx,
  output logic [5:0] raster_idx
);

  assign raster_idx = zz2raster(zz_idx);

endmodule

// File: rtl/izigzag_buffer.sv
// Ping-pong inverse zigzag buffer: writes arrive in zigzag order, reads leave in raster order.
// First raster word is valid the cycle after the 64th write; both sides sustain one word/cycle.
module izigzag_buffer
  import jpeg_pkg::*;
#(
  parameter int DW = COEF_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [DW-1:0] dout,
  output logic [5:0]    dout_idx,
  output logic          dout_last,
  output logic          dout_valid,
  input  logic          dout_ready
);

  localparam logic [5:0] LAST_IDX = 6'(BLK_SIZE - 1);

  logic [DW-1:0] mem [2][BLK_SIZE];
  logic [1:0]    full;
  logic          wsel;
  logic          rsel;
  logic [5:0]    wcnt;
  logic [5:0]    rcnt;
  logic [5:0]    waddr;
  logic          wr_fire;
  logic          rd_fire;

  izigzag_lut u_lut (
    .zz_idx     (wcnt),
    .raster_idx (waddr)
  );

  assign din_ready  = !full[wsel];
  assign dout_valid = full[rsel];
  assign dout       = mem[rsel][rcnt];
  assign dout_idx   = rcnt;
  assign dout_last  = (rcnt == LAST_IDX);

  assign wr_fire = din_valid && din_ready;
  assign rd_fire = dout_valid && dout_ready;

  // Array is deliberately not reset; contents are only exposed once a bank is marked full.
  always_ff @(posedge clk) begin
    if (wr_fire && !clr) begin
      mem[wsel][waddr] <= din;
    end
  end

  // A bank can only complete writing while not full and complete reading while full,
  // so a same-cycle write and read completion always touch different full bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
      wsel <= 1'b0;
      rsel <= 1'b0;
      wcnt <= 6'd0;
      rcnt <= 6'd0;
    end else if (clr) begin
      full <= 2'b00;
      wsel <= 1'b0;
      rsel <= 1'b0;
      wcnt <= 6'd0;
      rcnt <= 6'd0;
    end else begin
      if (wr_fire) begin
        wcnt <= wcnt + 6'd1;
        if (wcnt == LAST_IDX) begin
          full[wsel] <= 1'b1;
          wsel       <= !wsel;
        end
      end
      if (rd_fire) begin
        rcnt <= rcnt + 6'd1;
        if (rcnt == LAST_IDX) begin
          full[rsel] <= 1'b0;
          rsel       <= !rsel;
        end
      end
    end
  end

endmodule

// File: tb/tb_izigzag_buffer.sv
// Randomized scoreboard bench for izigzag_buffer with an independent diagonal-walk zigzag model.
module tb_izigzag_buffer;

  localparam int DW = 12;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic [5:0]    dout_idx;
  logic          dout_last;
  logic          dout_valid;
  logic          dout_ready;

  izigzag_buffer #(.DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_idx   (dout_idx),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  int zz_pos [64];         // zigzag index -> raster position, from the diagonal walk
  int cur [64];            // block currently being written, zigzag order
  int widx = 0;
  int acc_cnt = 0;
  int blocks_done = 0;
  bit pattern_mode = 1'b0;
  int rdy_mode = 0;        // 0: always ready, 1: random, 2: stalled

  int exp_val [$];
  int exp_idx [$];
  int cap [64];
  int pop_n = 0;
  int first_pop = 0;
  int last_pop = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz_pos[k] = r * 8 + (s - r);
          k++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          zz_pos[k] = r * 8 + (s - r);
          k++;
        end
      end
    end
  endtask

  task automatic new_block();
    for (int k = 0; k < 64; k++) begin
      cur[k] = pattern_mode ? k : int'($urandom_range(0, (1 << DW) - 1));
    end
    widx = 0;
  endtask

  task automatic push_block();
    int raster [64];
    for (int k = 0; k < 64; k++) raster[zz_pos[k]] = cur[k];
    for (int r = 0; r < 64; r++) begin
      exp_val.push_back(raster[r]);
      exp_idx.push_back(r);
    end
    blocks_done++;
  endtask

  task automatic abort_model();
    exp_val.delete();
    exp_idx.delete();
    new_block();
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic drive_cycle(input bit v);
    din_valid = v;
    din = DW'(cur[widx]);
    @(negedge clk);
    if (din_valid && din_ready) begin
      acc_cnt++;
      widx++;
      if (widx == 64) begin
        push_block();
        new_block();
      end
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    din_valid = 1'b0;
    while (exp_val.size() > 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_complete", exp_val.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (rdy_mode)
        0:       dout_ready = 1'b1;
        2:       dout_ready = 1'b0;
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare every accepted output and check stall stability.
  initial begin
    bit          held = 1'b0;
    logic [DW-1:0] hold_d;
    logic [5:0]    hold_i;
    forever begin
      @(negedge clk);
      if (rst_n && !clr && dout_valid) begin
        if (held) begin
          chk("stall_dout_stable", int'(dout), int'(hold_d));
          chk("stall_idx_stable", int'(dout_idx), int'(hold_i));
        end
        if (dout_ready) begin
          held = 1'b0;
          if (exp_val.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_output: got idx %0d data %0d, expected no output", dout_idx, dout);
          end else begin
            int ev, ei;
            ev = exp_val.pop_front();
            ei = exp_idx.pop_front();
            chk("dout_data", int'(dout), ev);
            chk("dout_idx", int'(dout_idx), ei);
            chk("dout_last", int'(dout_last), (ei == 63) ? 1 : 0);
            cap[dout_idx] = int'(dout);
            if (pop_n == 0) first_pop = cyc;
            last_pop = cyc;
            pop_n++;
          end
        end else begin
          held   = 1'b1;
          hold_d = dout;
          hold_i = dout_idx;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    int t;
    build_zz();
    rst_n      = 1'b0;
    clr        = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    #12;
    chk("reset_din_ready", int'(din_ready), 1);
    chk("reset_dout_valid", int'(dout_valid), 0);
    chk("reset_dout_last", int'(dout_last), 0);
    chk("reset_dout_idx", int'(dout_idx), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single block of ramp values: known raster placement and latency.
    pattern_mode = 1'b1;
    new_block();
    for (int i = 0; i < 63; i++) drive_cycle(1'b1);
    chk("lat_not_early", int'(dout_valid), 0);
    drive_cycle(1'b1);
    chk("lat_first_valid", int'(dout_valid), 1);
    chk("lat_first_idx", int'(dout_idx), 0);
    wait_drain();
    chk("ramp_r0", cap[0], 0);
    chk("ramp_r1", cap[1], 1);
    chk("ramp_r2", cap[2], 5);
    chk("ramp_r3", cap[3], 6);
    chk("ramp_r8", cap[8], 2);
    chk("ramp_r9", cap[9], 4);
    chk("ramp_r63", cap[63], 63);
    pattern_mode = 1'b0;
    new_block();

    // Three back-to-back blocks at full rate.
    pop_n = 0;
    for (int i = 0; i < 192; i++) begin
      chk("b2b_din_ready", int'(din_ready), 1);
      drive_cycle(1'b1);
    end
    wait_drain();
    chk("b2b_count", pop_n, 192);
    chk("b2b_no_gaps", last_pop - first_pop, 191);

    // Reader stalled: two banks fill, then writer is held off.
    rdy_mode = 2;
    acc_cnt  = 0;
    for (int i = 0; i < 200; i++) drive_cycle(1'b1);
    chk("stall_accepted", acc_cnt, 128);
    chk("stall_din_ready", int'(din_ready), 0);
    chk("stall_dout_valid", int'(dout_valid), 1);
    rdy_mode = 0;
    wait_drain();
    chk("stall_release_din_ready", int'(din_ready), 1);

    // Random valid/ready over 20 blocks.
    rdy_mode    = 1;
    blocks_done = 0;
    t = 0;
    while (blocks_done < 20 && t < 20000) begin
      drive_cycle(1'($urandom_range(0, 1)));
      t++;
    end
    chk("rand_blocks", blocks_done, 20);
    rdy_mode = 0;
    wait_drain();

    // Reset pulse in the middle of a block.
    for (int i = 0; i < 30; i++) drive_cycle(1'b1);
    rst_n = 1'b0;
    #2;
    chk("midrst_dout_valid", int'(dout_valid), 0);
    chk("midrst_din_ready", int'(din_ready), 1);
    abort_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) drive_cycle(1'b1);
    wait_drain();

    // clr with one bank full, the other half filled, and a same-cycle accept.
    rdy_mode = 2;
    acc_cnt  = 0;
    t = 0;
    while (acc_cnt < 96 && t < 500) begin
      drive_cycle(1'b1);
      t++;
    end
    chk("clr_prefill", acc_cnt, 96);
    clr       = 1'b1;
    din_valid = 1'b1;
    din       = DW'(12'h5A5);
    @(posedge clk);
    #1;
    clr       = 1'b0;
    din_valid = 1'b0;
    abort_model();
    chk("clr_dout_valid", int'(dout_valid), 0);
    chk("clr_din_ready", int'(din_ready), 1);
    chk("clr_dout_idx", int'(dout_idx), 0);
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) drive_cycle(1'b0);
    chk("clr_no_stale", int'(dout_valid), 0);
    for (int i = 0; i < 64; i++) drive_cycle(1'b1);
    wait_drain();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0);
    chk("final_idle", int'(dout_valid), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/izigzag_buffer.md
# izigzag_buffer

Inverse zigzag reorder buffer for the JPEG datapath: accepts 8x8 coefficient blocks in zigzag scan order (as produced by fdct_zigzag) and re-emits each block in raster (row-major) order. Two 64-entry banks in ping-pong, so one block can be written while the previous block drains. Sits on the decode/verification side as the receiving end of the zigzag stream, feeding raster-order consumers (IDCT, golden-model comparators).

## Interface
- DW, 12, coefficient width (signed, two's complement)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort: drop partial/pending blocks, return to reset state
- din  in  DW  coefficient, zigzag order
- din_valid  in  1  din qualifier
- din_ready  out  1  buffer can accept din this cycle
- dout  out  DW  coefficient, raster order
- dout_idx  out  6  raster index of dout (row*8+col)
- dout_last  out  1  dout_idx == 63
- dout_valid  out  1  dout qualifier
- dout_ready  in  1  consumer accepts dout this cycle

## Operation
- Storage: bank[0..1][0..63] of DW bits; per-bank flag full[b]; write pointer wsel, wcnt[5:0]; read pointer rsel, rcnt[5:0].
- Write: transfer when din_valid && din_ready; stores din at bank[wsel][ZZ2RASTER[wcnt]], wcnt++. On transfer with wcnt==63: full[wsel]<=1, wsel toggles, wcnt wraps to 0.
- din_ready = !full[wsel].
- Read: dout_valid = full[rsel]; dout = bank[rsel][rcnt]; dout_idx = rcnt. Transfer when dout_valid && dout_ready: rcnt++. On transfer with rcnt==63: full[rsel]<=0, rsel toggles, rcnt wraps to 0.
- Per-bank states: FILLING (wsel points to it, !full) -> FULL (64th write) -> DRAINING (rsel points, full) -> EMPTY (64th read).
- Simultaneous completion of write into one bank and drain of the other in same cycle: both flag updates apply; no conflict (different banks).
- Both banks full: din_ready=0 until reader frees a bank; no data lost or overwritten.
- Backpressure: dout/dout_idx hold stable while dout_valid && !dout_ready.
- clr: full[*]<=0, wsel=rsel=0, wcnt=rcnt=0; bank contents untouched. clr wins over any same-cycle transfer.
- No handling of out-of-range data; width preserved, no arithmetic.

## Timing
- Reset values: din_ready=1, dout_valid=0, dout_last=0, dout_idx=0, dout=bank contents (don't-care, X-tolerant in bench), all flags/pointers 0.
- Latency: first raster word valid the cycle after the 64th zigzag word is accepted.
- Throughput: one word/cycle each side sustained; continuous back-to-back blocks with dout_ready=1 never deassert din_ready.
- rst_n asserted mid-block: partial block discarded immediately; after release, the next din word is zigzag index 0 of a new block.
- dout path combinational from flop array (registered state only); din_ready combinational from flags only, not from din_valid.

## Structure
- jpeg_pkg: BLK_SIZE=64, ZZ2RASTER constant array (64 x 6-bit, zigzag index -> raster index), coefficient typedef parameterised on DW.
- One sub-module: izigzag_lut (combinational 6-bit zigzag -> raster map, sourced from jpeg_pkg) so the same table can be reused by the bench scoreboard.

## Test plan
- Single block, din = zigzag index k (0..63), dout_ready=1 -> dout at raster idx 0,1,2,3,8,9,63 equals 0,1,5,6,2,4,63; dout_last high only at idx 63; first dout_valid 1 cycle after 64th input.
- Three back-to-back blocks, dout_ready=1 -> din_ready stays 1 throughout, 192 outputs in order, no gaps after first block.
- dout_ready=0 for 200 cycles while feeding -> after 128 accepted inputs din_ready=0; release -> both blocks drain intact in order, then din_ready=1.
- Random din_valid/dout_ready toggling (50%) over 20 blocks -> every output matches reference reorder; dout stable under stall.
- rst_n pulse after 30 words of a block -> dout_valid=0, din_ready=1; next full block emits correctly from index 0.
- clr asserted with one bank full and other half-filled, same cycle as an accept -> all flags clear, next block reorders correctly, no stale output.
